uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_fifo
// Brief  : FIFO-buffered 8N1 UART transmitter, single clock (sysclk).
// Rev    : 1.0  initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int unsigned BAUD_DIV = 10416,
  parameter int unsigned ADDR_W   = 3
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              PC_Uart_txd
);

  localparam int unsigned           c_DEPTH     = 2 ** ADDR_W;
  localparam int unsigned           c_BAUD_W    = $clog2(BAUD_DIV);
  localparam logic [c_BAUD_W-1:0]   c_BAUD_LAST = c_BAUD_W'(BAUD_DIV - 1);
  localparam logic [ADDR_W:0]       c_FULL_CNT  = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic [7:0]          r_mem [c_DEPTH];
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic [ADDR_W:0]     r_count;
  logic                r_overflow;

  state_t              r_state;
  state_t              w_state_next;
  logic [c_BAUD_W-1:0] r_baud;
  logic [c_BAUD_W-1:0] w_baud_next;
  logic [2:0]          r_bit;
  logic [2:0]          w_bit_next;
  logic [2:0]          w_bit_inc;
  logic [7:0]          r_shift;
  logic [7:0]          w_shift_next;
  logic                r_txd;
  logic                w_txd_next;
  logic                r_done;
  logic                w_done_next;
  logic                w_push;
  logic                w_pop;
  logic                w_baud_end;

  assign full        = (r_count == c_FULL_CNT);
  assign empty       = (r_count == '0);
  assign count       = r_count;
  assign overflow    = r_overflow;
  assign tx_busy     = (r_state != S_IDLE);
  assign tx_done     = r_done;
  assign PC_Uart_txd = r_txd;

  // Full comes from the registered count, so a pop in the same cycle cannot rescue a push.
  assign w_push     = wr_en & ~full;
  assign w_baud_end = (r_baud == c_BAUD_LAST);
  assign w_bit_inc  = r_bit + 3'd1;

  always_ff @(posedge sysclk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= wr_en & full;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_txd   <= w_txd_next;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_baud_next  = w_baud_end ? '0 : r_baud + c_BAUD_W'(1);
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_txd_next   = r_txd;
    w_done_next  = 1'b0;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_baud_next = '0;
        w_txd_next  = 1'b1;
        if (!empty) begin
          w_pop        = 1'b1;
          w_shift_next = r_mem[r_rd_ptr];
          w_txd_next   = 1'b0;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_baud_end) begin
          w_txd_next   = r_shift[0];
          w_bit_next   = 3'd0;
          w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          if (r_bit == 3'd7) begin
            w_txd_next   = 1'b1;
            w_state_next = S_STOP;
          end else begin
            w_bit_next = w_bit_inc;
            w_txd_next = r_shift[w_bit_inc];
          end
        end
      end
      S_STOP: begin
        if (w_baud_end) begin
          w_done_next = 1'b1;
          // Chain straight into the next start bit so queued frames are contiguous.
          if (!empty) begin
            w_pop        = 1'b1;
            w_shift_next = r_mem[r_rd_ptr];
            w_txd_next   = 1'b0;
            w_state_next = S_START;
          end else begin
            w_txd_next   = 1'b1;
            w_state_next = S_IDLE;
          end
        end
      end
      default: begin
        w_txd_next   = 1'b1;
        w_state_next = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_tx_fifo
// Brief  : Directed self-checking bench for uart_tx_fifo at BAUD_DIV=4.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  logic       sysclk  = 1'b0;
  logic       reset   = 1'b1;
  logic       wr_en   = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, overflow, tx_busy, tx_done, txd;
  logic [3:0] count;

  int checks   = 0;
  int failures = 0;

  always #5 sysclk = ~sysclk;

  uart_tx_fifo #(
    .BAUD_DIV (4),
    .ADDR_W   (3)
  ) dut (
    .sysclk      (sysclk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .overflow    (overflow),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .PC_Uart_txd (txd)
  );

  // Serial monitor: samples mid-bit on the falling clock edge, 4 cycles per bit.
  logic [7:0] mon_q [$];
  int         mon_stop_err = 0;
  bit         mon_active   = 1'b0;
  int         mon_idx      = 0;
  logic [7:0] mon_byte     = 8'h00;

  always @(negedge sysclk) begin
    if (!reset) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (txd === 1'b0) begin
        mon_active = 1'b1;
        mon_idx    = 0;
        mon_byte   = 8'h00;
      end
    end else begin
      mon_idx++;
      if (mon_idx >= 6 && mon_idx <= 34 && (mon_idx % 4) == 2) begin
        mon_byte[3'((mon_idx - 6) / 4)] = txd;
      end else if (mon_idx == 38) begin
        if (txd !== 1'b1) mon_stop_err++;
        mon_q.push_back(mon_byte);
        mon_active = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    repeat (3) step();
    checks++; if (txd !== 1'b1)     begin failures++; $display("FAIL reset_txd got=%b exp=1", txd); end
    checks++; if (count !== 4'd0)   begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if ({empty, full} !== 2'b10) begin failures++; $display("FAIL reset_flags got empty=%b full=%b exp empty=1 full=0", empty, full); end
    checks++; if ({tx_busy, tx_done, overflow} !== 3'b000) begin failures++; $display("FAIL reset_status got busy=%b done=%b ovf=%b exp 0 0 0", tx_busy, tx_done, overflow); end
    reset = 1'b1;
    repeat (2) step();
    checks++; if ({txd, tx_busy, empty} !== 3'b101) begin failures++; $display("FAIL post_reset_idle got txd=%b busy=%b empty=%b exp 1 0 1", txd, tx_busy, empty); end
  endtask

  task automatic test_single_frame();
    logic [9:0] pat;
    pat = 10'b11_0100_1010;
    mon_q.delete();
    wr_data = 8'hA5; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    checks++; if ({count, txd, tx_busy} !== {4'd1, 1'b1, 1'b0}) begin failures++; $display("FAIL push_latency got count=%0d txd=%b busy=%b exp 1 1 0", count, txd, tx_busy); end
    step();
    checks++; if ({count, txd, tx_busy} !== {4'd0, 1'b0, 1'b1}) begin failures++; $display("FAIL pop_edge got count=%0d txd=%b busy=%b exp 0 0 1", count, txd, tx_busy); end
    for (int i = 1; i < 40; i++) begin
      step();
      checks++;
      if ({txd, tx_busy, tx_done} !== {pat[i/4], 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL a5_line cyc=%0d got txd=%b busy=%b done=%b exp %b 1 0", i, txd, tx_busy, tx_done, pat[i/4]);
      end
    end
    step();
    checks++; if ({tx_done, tx_busy, txd} !== 3'b101) begin failures++; $display("FAIL a5_end got done=%b busy=%b txd=%b exp 1 0 1", tx_done, tx_busy, txd); end
    step();
    checks++; if (tx_done !== 1'b0) begin failures++; $display("FAIL a5_done_pulse got=%b exp=0", tx_done); end
    checks++; if (mon_q.size() != 1) begin failures++; $display("FAIL a5_mon_size got=%0d exp=1", mon_q.size()); end
    else begin
      checks++; if (mon_q[0] !== 8'hA5) begin failures++; $display("FAIL a5_mon_byte got=%h exp=a5", mon_q[0]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [3];
    int busy_cnt;
    int done_cnt;
    exp_b    = '{8'h00, 8'hFF, 8'h3C};
    busy_cnt = 0;
    done_cnt = 0;
    mon_q.delete();
    wr_data = 8'h00; wr_en = 1'b1;
    step();
    wr_data = 8'hFF;
    step();
    for (int i = 0; i < 125; i++) begin
      if (i > 0) step();
      if (i == 0) wr_data = 8'h3C;
      if (i == 1) wr_en = 1'b0;
      busy_cnt += int'(tx_busy);
      done_cnt += int'(tx_done);
      if (i == 40) begin
        checks++; if ({txd, tx_busy, tx_done} !== 3'b011) begin failures++; $display("FAIL b2b_no_gap got txd=%b busy=%b done=%b exp 0 1 1", txd, tx_busy, tx_done); end
      end
      if (i == 79) begin
        checks++; if ({count, empty} !== {4'd1, 1'b0}) begin failures++; $display("FAIL b2b_before_pop3 got count=%0d empty=%b exp 1 0", count, empty); end
      end
      if (i == 80) begin
        checks++; if ({count, empty} !== {4'd0, 1'b1}) begin failures++; $display("FAIL b2b_after_pop3 got count=%0d empty=%b exp 0 1", count, empty); end
      end
    end
    checks++; if (busy_cnt != 120) begin failures++; $display("FAIL b2b_busy_cycles got=%0d exp=120", busy_cnt); end
    checks++; if (done_cnt != 3)   begin failures++; $display("FAIL b2b_done_pulses got=%0d exp=3", done_cnt); end
    checks++; if (mon_q.size() != 3) begin failures++; $display("FAIL b2b_mon_size got=%0d exp=3", mon_q.size()); end
    else begin
      for (int k = 0; k < 3; k++) begin
        checks++; if (mon_q[k] !== exp_b[k]) begin failures++; $display("FAIL b2b_byte%0d got=%h exp=%h", k, mon_q[k], exp_b[k]); end
      end
    end
  endtask

  task automatic test_overflow();
    int waited;
    mon_q.delete();
    wr_data = 8'hC3; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    step();
    for (int k = 1; k <= 9; k++) begin
      wr_data = 8'(k); wr_en = 1'b1;
      step();
      if (k == 8) begin
        checks++; if ({count, full, overflow} !== {4'd8, 1'b1, 1'b0}) begin failures++; $display("FAIL ovf_fill got count=%0d full=%b ovf=%b exp 8 1 0", count, full, overflow); end
      end
      if (k == 9) begin
        checks++; if ({count, full, overflow} !== {4'd8, 1'b1, 1'b1}) begin failures++; $display("FAIL ovf_drop got count=%0d full=%b ovf=%b exp 8 1 1", count, full, overflow); end
      end
    end
    wr_en = 1'b0;
    step();
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_single_pulse got=%b exp=0", overflow); end
    repeat (29) step();
    checks++; if ({count, tx_busy, tx_done} !== {4'd8, 1'b1, 1'b0}) begin failures++; $display("FAIL ovf_pre_stop got count=%0d busy=%b done=%b exp 8 1 0", count, tx_busy, tx_done); end
    wr_data = 8'hEE; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    checks++; if ({overflow, count, full} !== {1'b1, 4'd7, 1'b0}) begin failures++; $display("FAIL ovf_push_at_pop got ovf=%b count=%0d full=%b exp 1 7 0", overflow, count, full); end
    checks++; if ({tx_done, txd} !== 2'b10) begin failures++; $display("FAIL ovf_chain_start got done=%b txd=%b exp 1 0", tx_done, txd); end
    step();
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_pulse2_end got=%b exp=0", overflow); end
    waited = 0;
    while ((tx_busy || !empty) && waited < 500) begin
      step();
      waited++;
    end
    checks++; if (waited >= 500) begin failures++; $display("FAIL ovf_drain_timeout got busy=%b empty=%b exp 0 1", tx_busy, empty); end
    checks++; if (mon_q.size() != 9) begin failures++; $display("FAIL ovf_mon_size got=%0d exp=9", mon_q.size()); end
    else begin
      checks++; if (mon_q[0] !== 8'hC3) begin failures++; $display("FAIL ovf_byte0 got=%h exp=c3", mon_q[0]); end
      for (int k = 1; k < 9; k++) begin
        checks++; if (mon_q[k] !== 8'(k)) begin failures++; $display("FAIL ovf_byte%0d got=%h exp=%h", k, mon_q[k], 8'(k)); end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int low_cnt;
    int done_cnt;
    int busy_cnt;
    low_cnt  = 0;
    done_cnt = 0;
    busy_cnt = 0;
    mon_q.delete();
    wr_data = 8'h55; wr_en = 1'b1;
    step();
    wr_data = 8'h11;
    step();
    wr_data = 8'h22;
    step();
    wr_en = 1'b0;
    checks++; if (count !== 4'd2) begin failures++; $display("FAIL rst_mid_queued got=%0d exp=2", count); end
    repeat (9) step();
    checks++; if ({txd, tx_busy} !== 2'b01) begin failures++; $display("FAIL rst_mid_in_data got txd=%b busy=%b exp 0 1", txd, tx_busy); end
    #1 reset = 1'b0;
    #1;
    checks++; if (txd !== 1'b1) begin failures++; $display("FAIL rst_mid_txd_async got=%b exp=1", txd); end
    checks++; if ({count, empty, tx_busy, tx_done} !== {4'd0, 1'b1, 1'b0, 1'b0}) begin failures++; $display("FAIL rst_mid_state got count=%0d empty=%b busy=%b done=%b exp 0 1 0 0", count, empty, tx_busy, tx_done); end
    repeat (2) step();
    reset = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      low_cnt  += int'(txd === 1'b0);
      done_cnt += int'(tx_done);
      busy_cnt += int'(tx_busy);
    end
    checks++; if (low_cnt != 0)  begin failures++; $display("FAIL rst_mid_line_idle got_low_cycles=%0d exp=0", low_cnt); end
    checks++; if (done_cnt != 0 || busy_cnt != 0) begin failures++; $display("FAIL rst_mid_quiet got done=%0d busy=%0d exp 0 0", done_cnt, busy_cnt); end
    checks++; if (mon_q.size() != 0) begin failures++; $display("FAIL rst_mid_no_frame got=%0d exp=0", mon_q.size()); end
  endtask

  task automatic test_wrap();
    logic [7:0] vec [20];
    int         burst [3];
    int         idx;
    int         ovf_cnt;
    int         waited;
    vec   = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87,
              8'h98, 8'hA9, 8'hBA, 8'hCB, 8'hDC, 8'hED, 8'hFE,
              8'h0F, 8'h5A, 8'hA5, 8'h81, 8'h7E};
    burst = '{8, 7, 5};
    idx     = 0;
    ovf_cnt = 0;
    mon_q.delete();
    for (int b = 0; b < 3; b++) begin
      for (int j = 0; j < burst[b]; j++) begin
        wr_data = vec[idx]; wr_en = 1'b1;
        idx++;
        step();
        ovf_cnt += int'(overflow);
      end
      wr_en = 1'b0;
      step();
      ovf_cnt += int'(overflow);
      waited = 0;
      while (!empty && waited < 500) begin
        step();
        waited++;
      end
      checks++; if (waited >= 500) begin failures++; $display("FAIL wrap_burst%0d_timeout got count=%0d exp=0", b, count); end
    end
    waited = 0;
    while (tx_busy && waited < 100) begin
      step();
      waited++;
    end
    checks++; if (waited >= 100) begin failures++; $display("FAIL wrap_idle_timeout got busy=%b exp=0", tx_busy); end
    checks++; if (ovf_cnt != 0) begin failures++; $display("FAIL wrap_overflow got=%0d exp=0", ovf_cnt); end
    checks++; if (mon_stop_err != 0) begin failures++; $display("FAIL stop_bits got_errors=%0d exp=0", mon_stop_err); end
    checks++; if (mon_q.size() != 20) begin failures++; $display("FAIL wrap_mon_size got=%0d exp=20", mon_q.size()); end
    else begin
      for (int k = 0; k < 20; k++) begin
        checks++; if (mon_q[k] !== vec[k]) begin failures++; $display("FAIL wrap_byte%0d got=%h exp=%h", k, mon_q[k], vec[k]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire
